// File: rtl/interp_pass_sequencer.sv
// Issue sequencer for the HEVC sub-pixel interpolation datapath: one horizontal
// pass over the integer rows, then four vertical column passes, with delayed write strobes.
module interp_pass_sequencer #(
  parameter int NUM_PIXEL   = 8,
  parameter int FIR_LATENCY = 1,
  parameter int IDX_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic             issue_vld,
  output logic [1:0]       src_sel,
  output logic             dir,
  output logic [IDX_W-1:0] idx,
  output logic             wr_en,
  output logic [1:0]       wr_src,
  output logic             wr_dir,
  output logic [IDX_W-1:0] wr_idx
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HORIZ = 3'd1,
    VERT  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic             vld;
    logic [1:0]       src;
    logic             dir;
    logic [IDX_W-1:0] idx;
  } stage_t;

  localparam int unsigned     LAT      = FIR_LATENCY;
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(NUM_PIXEL + 6);
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(NUM_PIXEL - 1);

  state_t           state, state_next;
  logic [IDX_W-1:0] idx_q, idx_next;
  logic [1:0]       src_q, src_next;
  logic             issue;
  logic             pending;
  stage_t           pipe [0:LAT-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx_q <= '0;
      src_q <= '0;
    end else begin
      state <= state_next;
      idx_q <= idx_next;
      src_q <= src_next;
    end
  end

  // Valid beats still in flight ahead of the output stage; the beat sitting in
  // the output stage is written this cycle, so DRAIN may leave alongside it.
  always_comb begin
    pending = 1'b0;
    for (int unsigned i = 1; i < LAT; i++) begin
      pending = pending | pipe[i-1].vld;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx_q;
    src_next   = src_q;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = HORIZ;
          idx_next   = '0;
          src_next   = '0;
        end
      end
      HORIZ: begin
        if (!hold) begin
          issue = 1'b1;
          if (idx_q == LAST_ROW) begin
            state_next = VERT;
            idx_next   = '0;
            src_next   = '0;
          end else begin
            idx_next = idx_q + IDX_W'(1);
          end
        end
      end
      VERT: begin
        if (!hold) begin
          issue = 1'b1;
          if (idx_q == LAST_COL) begin
            idx_next = '0;
            src_next = src_q + 2'd1;
            if (src_q == 2'd3) state_next = DRAIN;
          end else begin
            idx_next = idx_q + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (!pending) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The FIR bank is free-running, so the pipe shifts every cycle regardless of hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= {issue, src_q, (state == VERT), idx_q};
      for (int unsigned i = 1; i < LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign issue_vld = issue;
  assign src_sel   = src_q;
  assign dir       = (state == VERT);
  assign idx       = idx_q;
  assign wr_en     = pipe[LAT-1].vld;
  assign wr_src    = pipe[LAT-1].src;
  assign wr_dir    = pipe[LAT-1].dir;
  assign wr_idx    = pipe[LAT-1].idx;

endmodule

// File: tb/tb_interp_pass_sequencer.sv
// Scoreboard bench for interp_pass_sequencer: three parameterisations share one
// clock; expected issue/write beats are queued at start acceptance and popped on output.
module tb_interp_pass_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       hold  = 1'b0;
  logic [2:0] start_v = '0;
  int         sel = 0;
  int         errors = 0;
  int         checks = 0;

  logic [2:0] busy_a, done_a, iv_a, dir_a, wen_a, wdir_a;
  logic [1:0] src_a  [3];
  logic [1:0] wsrc_a [3];
  logic [7:0] idx_a  [3];
  logic [7:0] widx_a [3];

  logic       o_busy, o_done, o_iv, o_dir, o_wen, o_wdir;
  logic [1:0] o_src, o_wsrc;
  logic [7:0] o_idx, o_widx;

  typedef struct {
    int          due;
    logic [10:0] b;
  } wr_t;

  always #5 clock = ~clock;

  interp_pass_sequencer #(.NUM_PIXEL(8), .FIR_LATENCY(1), .IDX_W(8)) u_def (
    .clock(clock), .reset(reset), .start(start_v[0]), .hold(hold),
    .busy(busy_a[0]), .done(done_a[0]), .issue_vld(iv_a[0]), .src_sel(src_a[0]),
    .dir(dir_a[0]), .idx(idx_a[0]), .wr_en(wen_a[0]), .wr_src(wsrc_a[0]),
    .wr_dir(wdir_a[0]), .wr_idx(widx_a[0]));

  interp_pass_sequencer #(.NUM_PIXEL(8), .FIR_LATENCY(3), .IDX_W(8)) u_lat3 (
    .clock(clock), .reset(reset), .start(start_v[1]), .hold(hold),
    .busy(busy_a[1]), .done(done_a[1]), .issue_vld(iv_a[1]), .src_sel(src_a[1]),
    .dir(dir_a[1]), .idx(idx_a[1]), .wr_en(wen_a[1]), .wr_src(wsrc_a[1]),
    .wr_dir(wdir_a[1]), .wr_idx(widx_a[1]));

  interp_pass_sequencer #(.NUM_PIXEL(4), .FIR_LATENCY(1), .IDX_W(8)) u_np4 (
    .clock(clock), .reset(reset), .start(start_v[2]), .hold(hold),
    .busy(busy_a[2]), .done(done_a[2]), .issue_vld(iv_a[2]), .src_sel(src_a[2]),
    .dir(dir_a[2]), .idx(idx_a[2]), .wr_en(wen_a[2]), .wr_src(wsrc_a[2]),
    .wr_dir(wdir_a[2]), .wr_idx(widx_a[2]));

  always_comb begin
    case (sel)
      1: begin
        o_busy = busy_a[1]; o_done = done_a[1]; o_iv = iv_a[1]; o_src = src_a[1];
        o_dir = dir_a[1]; o_idx = idx_a[1]; o_wen = wen_a[1]; o_wsrc = wsrc_a[1];
        o_wdir = wdir_a[1]; o_widx = widx_a[1];
      end
      2: begin
        o_busy = busy_a[2]; o_done = done_a[2]; o_iv = iv_a[2]; o_src = src_a[2];
        o_dir = dir_a[2]; o_idx = idx_a[2]; o_wen = wen_a[2]; o_wsrc = wsrc_a[2];
        o_wdir = wdir_a[2]; o_widx = widx_a[2];
      end
      default: begin
        o_busy = busy_a[0]; o_done = done_a[0]; o_iv = iv_a[0]; o_src = src_a[0];
        o_dir = dir_a[0]; o_idx = idx_a[0]; o_wen = wen_a[0]; o_wsrc = wsrc_a[0];
        o_wdir = wdir_a[0]; o_widx = widx_a[0];
      end
    endcase
  end

  // Runs one scenario on instance s from its cycle 0 (entered 1ns after a rising edge).
  task automatic run_check(input int s, input int np, input int lat, input int ncyc,
                           input bit held, input int hold_lo, input int hold_hi,
                           input int ign0, input int ign1, input int exp_blocks);
    logic [10:0] seq[$];
    logic [10:0] iq[$];
    wr_t         wq[$];
    wr_t         w;
    logic [10:0] got, exp;
    int          phase = 0;
    int          done_at = -1;
    int          blocks = 0;
    bit          st, hd, exp_iss, exp_wen;
    for (int r = 0; r < np + 7; r++) seq.push_back({2'd0, 1'b0, 8'(r)});
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < np; c++) seq.push_back({2'(p), 1'b1, 8'(c)});
    sel = s;
    for (int c = 0; c < ncyc; c++) begin
      st = held || (c == 0) || (c == ign0) || (c == ign1);
      hd = (c >= hold_lo) && (c <= hold_hi);
      start_v = st ? 3'(1 << s) : 3'b000;
      hold = hd;
      @(negedge clock);
      exp_iss = (phase == 1) && !hd;
      checks += 3;
      if (o_busy !== (phase != 0)) begin
        errors++;
        $display("FAIL busy s=%0d c=%0d got=%b exp=%b", s, c, o_busy, (phase != 0));
      end
      if (o_done !== ((phase == 2) && (c == done_at))) begin
        errors++;
        $display("FAIL done s=%0d c=%0d got=%b exp=%b", s, c, o_done, ((phase == 2) && (c == done_at)));
      end
      if (o_iv !== exp_iss) begin
        errors++;
        $display("FAIL issue_vld s=%0d c=%0d got=%b exp=%b", s, c, o_iv, exp_iss);
      end
      if (exp_iss) begin
        exp = iq.pop_front();
        got = {o_src, o_dir, o_idx};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL issue_beat s=%0d c=%0d got=%h exp=%h", s, c, got, exp);
        end
        wq.push_back('{c + lat, exp});
        if (iq.size() == 0) begin
          phase = 2;
          done_at = c + lat + 1;
        end
      end
      exp_wen = (wq.size() > 0) && (wq[0].due == c);
      checks++;
      if (o_wen !== exp_wen) begin
        errors++;
        $display("FAIL wr_en s=%0d c=%0d got=%b exp=%b", s, c, o_wen, exp_wen);
      end
      if (exp_wen) begin
        w = wq.pop_front();
        got = {o_wsrc, o_wdir, o_widx};
        checks++;
        if (got !== w.b) begin
          errors++;
          $display("FAIL wr_beat s=%0d c=%0d got=%h exp=%h", s, c, got, w.b);
        end
      end
      if (phase == 0 && st) begin
        phase = 1;
        iq = seq;
      end else if (phase == 2 && c == done_at) begin
        phase = 0;
        blocks++;
      end
      @(posedge clock);
      #1;
    end
    start_v = '0;
    hold = 1'b0;
    checks += 2;
    if (blocks != exp_blocks) begin
      errors++;
      $display("FAIL block_count s=%0d got=%0d exp=%0d", s, blocks, exp_blocks);
    end
    if (wq.size() != 0) begin
      errors++;
      $display("FAIL writes_outstanding s=%0d got=%0d exp=0", s, wq.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_v = '0;
    hold = 1'b0;
    repeat (2) @(posedge clock);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if ({o_busy, o_done, o_iv, o_src, o_dir, o_idx, o_wen, o_wsrc, o_wdir, o_widx} !== '0) begin
        errors++;
        $display("FAIL reset_outputs s=%0d got=%h exp=0", s,
                 {o_busy, o_done, o_iv, o_src, o_dir, o_idx, o_wen, o_wsrc, o_wdir, o_widx});
      end
    end
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_single_block();
    run_check(0, 8, 1, 52, 1'b0, -1, -2, -1, -1, 1);
  endtask

  task automatic test_hold();
    run_check(0, 8, 1, 55, 1'b0, 5, 7, -1, -1, 1);
  endtask

  task automatic test_start_ignored();
    run_check(0, 8, 1, 60, 1'b0, -1, -2, 10, 49, 1);
  endtask

  task automatic test_reset_mid();
    sel = 0;
    start_v = 3'b001;
    @(posedge clock);
    #1 start_v = '0;
    repeat (29) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({o_iv, o_src, o_dir, o_idx} !== {1'b1, 2'd1, 1'b1, 8'd6}) begin
      errors++;
      $display("FAIL mid_block_beat got=%h exp=%h", {o_iv, o_src, o_dir, o_idx}, {1'b1, 2'd1, 1'b1, 8'd6});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({o_busy, o_done, o_iv, o_src, o_dir, o_idx, o_wen, o_wsrc, o_wdir, o_widx} !== '0) begin
      errors++;
      $display("FAIL async_reset got=%h exp=0",
               {o_busy, o_done, o_iv, o_src, o_dir, o_idx, o_wen, o_wsrc, o_wdir, o_widx});
    end
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    run_check(0, 8, 1, 52, 1'b0, -1, -2, -1, -1, 1);
  endtask

  task automatic test_latency3();
    run_check(1, 8, 3, 54, 1'b0, -1, -2, -1, -1, 1);
  endtask

  task automatic test_back_to_back();
    run_check(2, 4, 1, 90, 1'b1, -1, -2, -1, -1, 3);
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_hold();
    test_start_ignored();
    test_reset_mid();
    test_latency3();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
